dict_stream_decompressor: RTL and testbench
===========================================

# dict_stream_decompressor

Parametrised, streaming successor of the fixed 4-bit/8-entry dictionary decompressor. It accepts codebook indices over a valid/ready handshake and looks each one up in a runtime-writable codebook register file. Each looked-up chunk passes through a one-entry holding register into a shift register, which emits it serially over a second valid/ready handshake with a last-bit marker. The block sits between the compressed-index source and the unary/serial consumer, and sustains back-to-back chunks with no idle cycles.

## Interface
- CHUNK_SIZE, 4, bits per codebook entry (≥2)
- CODEBOOK_SIZE, 8, number of entries (≥2)
- INDEX_BITS, $clog2(CODEBOOK_SIZE), index width
- LSB_FIRST, 0, 0 = serialise MSB first, 1 = LSB first
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cb_wr_en  input  1  codebook write strobe
- cb_wr_addr  input  INDEX_BITS  entry to write
- cb_wr_data  input  CHUNK_SIZE  new entry value
- in_valid  input  1  in_index valid
- in_ready  output  1  block can accept an index this cycle
- in_index  input  INDEX_BITS  compressed index
- out_valid  output  1  out_bit valid
- out_ready  input  1  consumer takes out_bit this cycle
- out_bit  output  1  current serial bit
- out_last  output  1  out_bit is the final bit of its chunk
- busy  output  1  holding register or shifter occupied

## Operation
- Codebook: CODEBOOK_SIZE×CHUNK_SIZE flops.
  - Reset contents: for CHUNK_SIZE=4 and CODEBOOK_SIZE=8, entries 0..7 = 0000, 0010, 1001, 1011, 1111, 1000, 1100, 0111.
  - Any other parametrisation resets entry i to i, truncated or zero-extended to CHUNK_SIZE.
  - A write takes effect at the edge where cb_wr_en is sampled high.
  - Index ≥ CODEBOOK_SIZE (non-power-of-2 sizes) looks up all zeros.
- Input accept: occurs on in_valid && in_ready. hold_data <= codebook[in_index] and hold_valid <= 1.
  - Lookup uses the codebook contents before any same-cycle write (read-before-write).
- Transfer: the holding register moves to the shifter when hold_valid && (shifter empty || the shifter's last bit is consumed this cycle). The transfer clears hold_valid unless a new accept happens in the same cycle.
- in_ready = !rst && (!hold_valid || transfer). in_ready is combinational from out_ready.
- Shifter:
  - out_bit = shift_reg MSB (LSB_FIRST=0) or LSB (LSB_FIRST=1).
  - On out_valid && out_ready: shift by one toward the output end, zero-filled, and bit_cnt++.
  - out_last = out_valid && bit_cnt == CHUNK_SIZE-1. Consuming the last bit empties the shifter unless a transfer refills it.
- No handshake on out: out_bit, out_last and bit_cnt hold while out_valid && !out_ready.
- busy = hold_valid || out_valid.

## Timing
- Reset, sampled at an edge: out_valid=0, out_last=0, out_bit=0, busy=0, hold_valid=0, bit_cnt=0, codebook restored. in_ready=0 while rst is high.
- Reset mid-chunk discards the holding register and the remaining bits. Nothing is output afterwards until a new accept.
- Latency (idle block):
  - index accepted at edge k → holding register at k → shifter loaded at edge k+1.
  - out_valid high in the cycle after edge k+1, with the first bit of the chunk.
- Throughput with out_ready held high: one bit per cycle, one chunk every CHUNK_SIZE cycles, no bubble between chunks provided the next index is held by then.
- Simultaneous accept + transfer in one cycle is legal; the holding register takes the new chunk.
- Backpressure: out_ready low with the holding register full → in_ready=0 until the shifter's last bit is consumed.
- bit_cnt width is $clog2(CHUNK_SIZE). It wraps to 0 only on a transfer or on emptying.

## Structure
- Package dict_pkg:
  - default-codebook function default_entry(i, CHUNK_SIZE, CODEBOOK_SIZE)
  - LSB_FIRST encoding constants
- Sub-module dict_p2s_shifter: shift register, bit_cnt, out handshake, out_last.
  - Parameters CHUNK_SIZE and LSB_FIRST.
  - Exposes load, load_data, empty_next.
- Top level owns the codebook, the holding register and in_ready.

## Test plan
- Reset defaults, LSB_FIRST=0, out_ready=1: indices 2,7 back-to-back → serial 1,0,0,1,0,1,1,1. out_last high on bits 4 and 8. No gap between chunks. First out_valid 2 cycles after the first accept.
- Codebook write: entry 3 ← 0101, then index 3 → 0,1,0,1. Write entry 3 ← 1110 in the same cycle as accepting index 3 → old value 0101 emitted.
- Backpressure: queue indices 4,5,6 with out_ready toggling 1,0,0,1. Verify out_bit holds while stalled and in_ready drops while the holding register is full. Verify no index is lost: output 1111 1000 1100.
- LSB_FIRST=1: index 2 (1001) → 1,0,0,1; index 1 (0010) → 0,1,0,0.
- CHUNK_SIZE=6, CODEBOOK_SIZE=5: index 4 → 000100. Index 6 → 000000.
- Assert rst during bit 2 of chunk 1111 → out_valid=0 next cycle, codebook back to defaults, index 0 then emits 0000.

Source files
------------

// File: rtl/dict_pkg.sv
// Purpose: shared constants and default-codebook helper for dict_stream_decompressor.
// Latency: n/a (no logic of its own).
// Backpressure: n/a.
// Ports: none (package).
package dict_pkg;

  // Serialisation order encodings for the LSB_FIRST parameter.
  localparam bit SER_MSB_FIRST = 1'b0;
  localparam bit SER_LSB_FIRST = 1'b1;

  // Reset value of codebook entry i. The 4-bit/8-entry shape keeps the table of the
  // fixed predecessor so existing compressed streams decode unchanged; any other
  // shape resets entry i to i (the caller truncates/zero-extends to its chunk width).
  function automatic logic [31:0] default_entry(input int i, input int chunk_size,
                                                input int codebook_size);
    logic [31:0] e;
    e = 32'(i);
    if (chunk_size == 4 && codebook_size == 8) begin
      case (i)
        0:       e = 32'h0;
        1:       e = 32'h2;
        2:       e = 32'h9;
        3:       e = 32'hB;
        4:       e = 32'hF;
        5:       e = 32'h8;
        6:       e = 32'hC;
        7:       e = 32'h7;
        default: e = 32'(i);
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/dict_p2s_shifter.sv
// Purpose: parallel-to-serial shifter emitting one chunk bit per out handshake, with last marker.
// Latency: load at edge k -> first bit valid in the cycle after edge k.
// Backpressure: out_bit/out_last/bit count hold while out_valid && !out_ready.
// Ports: clk/rst; load + load_data (chunk to shift out); empty_next (shifter is free to be
//        loaded at the coming edge); out_valid/out_ready/out_bit/out_last serial stream.
module dict_p2s_shifter
  import dict_pkg::*;
#(
  parameter int CHUNK_SIZE = 4,
  parameter bit LSB_FIRST  = SER_MSB_FIRST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [CHUNK_SIZE-1:0] load_data,
  output logic                  empty_next,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic                  out_last
);

  localparam int               CNT_W    = $clog2(CHUNK_SIZE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNK_SIZE - 1);

  logic [CHUNK_SIZE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  valid_q, valid_d;
  logic                  fire;
  logic                  at_last;

  assign fire       = valid_q && out_ready;
  assign at_last    = valid_q && (bit_cnt_q == LAST_CNT);
  assign out_valid  = valid_q;
  assign out_last   = at_last;
  assign out_bit    = (LSB_FIRST == SER_LSB_FIRST) ? shift_q[0] : shift_q[CHUNK_SIZE-1];
  // Free at the next edge if idle now, or if the final bit leaves this cycle.
  assign empty_next = !valid_q || (fire && at_last);

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    valid_d   = valid_q;
    if (fire) begin
      shift_d = (LSB_FIRST == SER_LSB_FIRST) ? (shift_q >> 1) : (shift_q << 1);
      if (at_last) begin
        valid_d   = 1'b0;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
    // A load only arrives when empty_next is high, so it overrides the emptying above.
    if (load) begin
      shift_d   = load_data;
      bit_cnt_d = '0;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: rtl/dict_stream_decompressor.sv
// Purpose: codebook-index to serial-bit decompressor with runtime-writable codebook.
// Latency: index accepted at edge k -> first output bit valid in the cycle after edge k+1.
// Backpressure: in_ready drops while the holding register is full and the shifter cannot take it.
// Ports: clk/rst; cb_wr_en/cb_wr_addr/cb_wr_data codebook write; in_valid/in_ready/in_index
//        index stream; out_valid/out_ready/out_bit/out_last serial stream; busy status.
module dict_stream_decompressor
  import dict_pkg::*;
#(
  parameter int CHUNK_SIZE    = 4,
  parameter int CODEBOOK_SIZE = 8,
  parameter int INDEX_BITS    = $clog2(CODEBOOK_SIZE),
  parameter bit LSB_FIRST     = SER_MSB_FIRST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cb_wr_en,
  input  logic [INDEX_BITS-1:0] cb_wr_addr,
  input  logic [CHUNK_SIZE-1:0] cb_wr_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INDEX_BITS-1:0] in_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [INDEX_BITS:0] IDX_LIMIT = (INDEX_BITS + 1)'(CODEBOOK_SIZE);

  logic [CHUNK_SIZE-1:0] cb_q [CODEBOOK_SIZE];
  logic [CHUNK_SIZE-1:0] cb_d [CODEBOOK_SIZE];
  logic [CHUNK_SIZE-1:0] hold_data_q, hold_data_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [CHUNK_SIZE-1:0] lookup_data;
  logic                  idx_in_range, wr_in_range;
  logic                  accept, transfer, shift_empty_next;

  // Non-power-of-2 codebooks leave index codes with no entry; those decode as zero.
  assign idx_in_range = ({1'b0, in_index}   < IDX_LIMIT);
  assign wr_in_range  = ({1'b0, cb_wr_addr} < IDX_LIMIT);

  assign transfer = hold_valid_q && shift_empty_next;
  assign in_ready = !rst && (!hold_valid_q || transfer);
  assign accept   = in_valid && in_ready;
  assign busy     = hold_valid_q || out_valid;

  // Lookup reads the registered codebook, so a same-cycle write is not yet visible.
  always_comb begin
    lookup_data = '0;
    if (idx_in_range) lookup_data = cb_q[in_index];
  end

  always_comb begin
    cb_d = cb_q;
    if (cb_wr_en && wr_in_range) cb_d[cb_wr_addr] = cb_wr_data;
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (transfer) hold_valid_d = 1'b0;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = lookup_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CODEBOOK_SIZE; i++) begin
        cb_q[i] <= CHUNK_SIZE'(default_entry(i, CHUNK_SIZE, CODEBOOK_SIZE));
      end
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      cb_q         <= cb_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  dict_p2s_shifter #(
    .CHUNK_SIZE (CHUNK_SIZE),
    .LSB_FIRST  (LSB_FIRST)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (transfer),
    .load_data  (hold_data_q),
    .empty_next (shift_empty_next),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_dict_stream_decompressor.sv
// Purpose: self-checking bench for dict_stream_decompressor in three parametrisations.
// Latency: n/a.
// Backpressure: exercised via out_ready patterns in the vector table.
module tb_dict_stream_decompressor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cb_wr_en = 1'b0;
  logic [2:0] cb_wr_addr = '0;
  logic [3:0] cb_wr_data = '0;
  logic       in_valid = 1'b0;
  logic [2:0] in_index = '0;
  logic       out_ready = 1'b0;

  logic ir0, ov0, ob0, ol0, bz0;
  logic ir1, ov1, ob1, ol1, bz1;
  logic ir2, ov2, ob2, ol2, bz2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dict_stream_decompressor dut0 (
    .clk(clk), .rst(rst), .cb_wr_en(cb_wr_en), .cb_wr_addr(cb_wr_addr), .cb_wr_data(cb_wr_data),
    .in_valid(in_valid), .in_ready(ir0), .in_index(in_index), .out_valid(ov0),
    .out_ready(out_ready), .out_bit(ob0), .out_last(ol0), .busy(bz0));

  dict_stream_decompressor #(.LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cb_wr_en(cb_wr_en), .cb_wr_addr(cb_wr_addr), .cb_wr_data(cb_wr_data),
    .in_valid(in_valid), .in_ready(ir1), .in_index(in_index), .out_valid(ov1),
    .out_ready(out_ready), .out_bit(ob1), .out_last(ol1), .busy(bz1));

  dict_stream_decompressor #(.CHUNK_SIZE(6), .CODEBOOK_SIZE(5)) dut2 (
    .clk(clk), .rst(rst), .cb_wr_en(cb_wr_en), .cb_wr_addr(cb_wr_addr),
    .cb_wr_data({2'b00, cb_wr_data}),
    .in_valid(in_valid), .in_ready(ir2), .in_index(in_index), .out_valid(ov2),
    .out_ready(out_ready), .out_bit(ob2), .out_last(ol2), .busy(bz2));

  // exp = {out_valid, out_bit, out_last, in_ready, busy} of dut0
  typedef struct {
    logic       r;
    logic       iv;
    logic [2:0] idx;
    logic       ordy;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic iv, input logic [2:0] idx, input logic ordy,
                     input logic [4:0] e);
    vec_t v;
    v.r = r; v.iv = iv; v.idx = idx; v.ordy = ordy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, return at the following falling edge.
  task automatic cyc(input logic r, input logic iv, input logic [2:0] idx, input logic ordy,
                     input logic we, input logic [2:0] wa, input logic [3:0] wd);
    @(posedge clk);
    #1;
    rst = r; in_valid = iv; in_index = idx; out_ready = ordy;
    cb_wr_en = we; cb_wr_addr = wa; cb_wr_data = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 4'd0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 4'd0);
    idle();
  endtask

  task automatic send(input logic [2:0] idx);
    cyc(1'b0, 1'b1, idx, 1'b1, 1'b0, 3'd0, 4'd0);
  endtask

  // Collect n bits (first bit ends up most significant) from the selected instance.
  task automatic collect(input int which, input int n, output logic [15:0] bits,
                         output logic [15:0] lasts);
    int got;
    got = 0; bits = '0; lasts = '0;
    for (int t = 0; t < 40 && got < n; t++) begin
      logic v, b, l;
      case (which)
        0:       begin v = ov0; b = ob0; l = ol0; end
        1:       begin v = ov1; b = ob1; l = ol1; end
        default: begin v = ov2; b = ob2; l = ol2; end
      endcase
      if (v) begin
        bits  = {bits[14:0], b};
        lasts = {lasts[14:0], l};
        got++;
      end
      idle();
    end
    chk("collect_count", 16'(got), 16'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits, lasts;

    // Reset, then indices 2 and 7 back-to-back with out_ready high.
    add(1, 0, 0, 1, 5'b00000);
    add(0, 0, 0, 1, 5'b00010);
    add(0, 1, 2, 1, 5'b00010);
    add(0, 1, 7, 1, 5'b00011);
    add(0, 0, 0, 1, 5'b11001);
    add(0, 0, 0, 1, 5'b10001);
    add(0, 0, 0, 1, 5'b10001);
    add(0, 0, 0, 1, 5'b11111);
    add(0, 0, 0, 1, 5'b10011);
    add(0, 0, 0, 1, 5'b11011);
    add(0, 0, 0, 1, 5'b11011);
    add(0, 0, 0, 1, 5'b11111);
    add(0, 0, 0, 1, 5'b00010);
    // Backpressure: indices 4,5,6 with out_ready cycling 1,0,0,1.
    add(1, 0, 0, 1, 5'b00000);
    add(0, 1, 4, 1, 5'b00010);
    add(0, 1, 5, 0, 5'b00011);
    add(0, 1, 6, 0, 5'b11001);
    add(0, 1, 6, 1, 5'b11001);
    add(0, 1, 6, 1, 5'b11001);
    add(0, 1, 6, 0, 5'b11001);
    add(0, 1, 6, 0, 5'b11001);
    add(0, 1, 6, 1, 5'b11001);
    add(0, 1, 6, 1, 5'b11111);
    add(0, 0, 0, 0, 5'b11001);
    add(0, 0, 0, 0, 5'b11001);
    add(0, 0, 0, 1, 5'b11001);
    add(0, 0, 0, 1, 5'b10001);
    add(0, 0, 0, 0, 5'b10001);
    add(0, 0, 0, 0, 5'b10001);
    add(0, 0, 0, 1, 5'b10001);
    add(0, 0, 0, 1, 5'b10111);
    add(0, 0, 0, 0, 5'b11011);
    add(0, 0, 0, 0, 5'b11011);
    add(0, 0, 0, 1, 5'b11011);
    add(0, 0, 0, 1, 5'b11011);
    add(0, 0, 0, 0, 5'b10011);
    add(0, 0, 0, 0, 5'b10011);
    add(0, 0, 0, 1, 5'b10011);
    add(0, 0, 0, 1, 5'b10111);
    add(0, 0, 0, 0, 5'b00010);

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].iv, vecs[i].idx, vecs[i].ordy, 1'b0, 3'd0, 4'd0);
      chk($sformatf("vec%0d", i), {11'd0, ov0, ob0, ol0, ir0, bz0}, {11'd0, vecs[i].exp});
    end

    // Codebook write, then read-before-write on a same-cycle write + accept.
    do_reset();
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd3, 4'b0101);
    send(3'd3);
    collect(0, 4, bits, lasts);
    chk("cb_write_bits", bits, 16'h0005);
    chk("cb_write_last", lasts, 16'h0001);
    cyc(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 3'd3, 4'b1110);
    collect(0, 4, bits, lasts);
    chk("rbw_old_bits", bits, 16'h0005);
    send(3'd3);
    collect(0, 4, bits, lasts);
    chk("rbw_new_bits", bits, 16'h000E);

    // LSB-first instance.
    do_reset();
    send(3'd2);
    collect(1, 4, bits, lasts);
    chk("lsb_idx2_bits", bits, 16'h0009);
    chk("lsb_idx2_last", lasts, 16'h0001);
    send(3'd1);
    collect(1, 4, bits, lasts);
    chk("lsb_idx1_bits", bits, 16'h0004);

    // 6-bit chunks, 5-entry codebook, including an index with no entry.
    do_reset();
    send(3'd4);
    collect(2, 6, bits, lasts);
    chk("c6_idx4_bits", bits, 16'h0004);
    chk("c6_idx4_last", lasts, 16'h0001);
    send(3'd6);
    collect(2, 6, bits, lasts);
    chk("c6_idx6_bits", bits, 16'h0000);
    chk("c6_idx6_last", lasts, 16'h0001);

    // Reset in the middle of chunk 1111; the codebook must come back to defaults.
    do_reset();
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 4'b1010);
    send(3'd4);
    idle();
    chk("mid_pre_valid", {15'd0, ov0}, 16'h0000);
    idle();
    chk("mid_bit1", {14'd0, ov0, ob0}, 16'h0003);
    cyc(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 4'd0);
    chk("mid_bit2", {13'd0, ov0, ob0, ir0}, 16'h0006);
    idle();
    chk("mid_after_rst", {12'd0, ov0, ob0, ol0, bz0}, 16'h0000);
    idle();
    chk("mid_quiet", {14'd0, ov0, bz0}, 16'h0000);
    send(3'd0);
    collect(0, 4, bits, lasts);
    chk("rst_cb0_bits", bits, 16'h0000);
    chk("rst_cb0_last", lasts, 16'h0001);
    send(3'd3);
    collect(0, 4, bits, lasts);
    chk("rst_cb3_bits", bits, 16'h000B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
